// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write port arbiter merging ALU and mult/div writebacks
// ALU results win the port; mult/div results wait in a small FIFO and are killed by younger ALU writes.
module writeback_arbiter #(
   parameter int QDEPTH = 2
) (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        alu_wbValid,
   input  logic [4:0]  alu_wbReg,
   input  logic [31:0] alu_wbData,
   input  logic        md_valid,
   output logic        md_ready,
   input  logic [4:0]  md_reg,
   input  logic [31:0] md_data,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   input  logic [4:0]  ctrl_readRegA,
   input  logic [4:0]  ctrl_readRegB,
   output logic        bypass_hitA,
   output logic [31:0] bypass_dataA,
   output logic        bypass_hitB,
   output logic [31:0] bypass_dataB
);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int SW = PW + 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
   localparam logic [PW-1:0] LAST_C = PW'(QDEPTH - 1);

   logic          q_valid_q [QDEPTH];
   logic          q_valid_d [QDEPTH];
   logic [4:0]    q_reg_q   [QDEPTH];
   logic [4:0]    q_reg_d   [QDEPTH];
   logic [31:0]   q_data_q  [QDEPTH];
   logic [31:0]   q_data_d  [QDEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          wen_q, wen_d;
   logic [4:0]    wreg_q, wreg_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          alu_write, push, pop;
   logic [SW-1:0] slot_sum;
   logic [PW-1:0] slot;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PW'(1);
   endfunction

   assign md_ready  = (count_q < DEPTH_C) && !ctrl_reset;
   assign alu_write = alu_wbValid && (alu_wbReg != 5'd0);
   // A same-cycle ALU write to the same register is younger, so the md result is dropped.
   assign push      = md_valid && md_ready && (md_reg != 5'd0) &&
                      !(alu_wbValid && (alu_wbReg == md_reg));
   assign pop       = !alu_write && (count_q != '0);

   always_comb begin
      q_valid_d = q_valid_q;
      q_reg_d   = q_reg_q;
      q_data_d  = q_data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wen_d     = 1'b0;
      wreg_d    = wreg_q;
      wdata_d   = wdata_q;
      if (alu_write) begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (q_reg_q[PW'(i)] == alu_wbReg) q_valid_d[PW'(i)] = 1'b0;
         end
         wen_d   = 1'b1;
         wreg_d  = alu_wbReg;
         wdata_d = alu_wbData;
      end else if (pop) begin
         wen_d             = q_valid_q[head_q];
         wreg_d            = q_reg_q[head_q];
         wdata_d           = q_data_q[head_q];
         q_valid_d[head_q] = 1'b0;
         head_d            = ptr_inc(head_q);
      end
      if (push) begin
         q_valid_d[tail_q] = 1'b1;
         q_reg_d[tail_q]   = md_reg;
         q_data_d[tail_q]  = md_data;
         tail_d            = ptr_inc(tail_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Later slots in FIFO order overwrite earlier hits, so the youngest queued match wins.
   always_comb begin
      bypass_hitA  = 1'b0;
      bypass_dataA = '0;
      bypass_hitB  = 1'b0;
      bypass_dataB = '0;
      slot_sum     = '0;
      slot         = '0;
      if (wen_q && (wreg_q == ctrl_readRegA)) begin
         bypass_hitA  = 1'b1;
         bypass_dataA = wdata_q;
      end
      if (wen_q && (wreg_q == ctrl_readRegB)) begin
         bypass_hitB  = 1'b1;
         bypass_dataB = wdata_q;
      end
      for (int i = 0; i < QDEPTH; i++) begin
         slot_sum = SW'(head_q) + SW'(i);
         if (slot_sum >= SW'(QDEPTH)) slot_sum = slot_sum - SW'(QDEPTH);
         slot = slot_sum[PW-1:0];
         if ((CW'(i) < count_q) && q_valid_q[slot]) begin
            if (q_reg_q[slot] == ctrl_readRegA) begin
               bypass_hitA  = 1'b1;
               bypass_dataA = q_data_q[slot];
            end
            if (q_reg_q[slot] == ctrl_readRegB) begin
               bypass_hitB  = 1'b1;
               bypass_dataB = q_data_q[slot];
            end
         end
      end
      if ((ctrl_readRegA == 5'd0) || ctrl_reset) begin
         bypass_hitA  = 1'b0;
         bypass_dataA = '0;
      end
      if ((ctrl_readRegB == 5'd0) || ctrl_reset) begin
         bypass_hitB  = 1'b0;
         bypass_dataB = '0;
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         q_valid_q <= '{default: '0};
         q_reg_q   <= '{default: '0};
         q_data_q  <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         wen_q     <= 1'b0;
         wreg_q    <= '0;
         wdata_q   <= '0;
      end else begin
         q_valid_q <= q_valid_d;
         q_reg_q   <= q_reg_d;
         q_data_q  <= q_data_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         wen_q     <= wen_d;
         wreg_q    <= wreg_d;
         wdata_q   <= wdata_d;
      end
   end

   assign ctrl_writeEnable = wen_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter against a queue-based model
// The driver predicts each cycle's write-port value; a separate monitor compares after every edge.
module tb_writeback_arbiter;
   localparam int QD = 2;

   logic        clock = 1'b0;
   logic        ctrl_reset = 1'b0;
   logic        alu_wbValid = 1'b0;
   logic [4:0]  alu_wbReg = '0;
   logic [31:0] alu_wbData = '0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [4:0]  md_reg = '0;
   logic [31:0] md_data = '0;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA = '0;
   logic [4:0]  ctrl_readRegB = '0;
   logic        bypass_hitA, bypass_hitB;
   logic [31:0] bypass_dataA, bypass_dataB;

   always #5 clock = ~clock;

   writeback_arbiter #(.QDEPTH(QD)) dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .alu_wbValid(alu_wbValid), .alu_wbReg(alu_wbReg), .alu_wbData(alu_wbData),
      .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .bypass_hitA(bypass_hitA), .bypass_dataA(bypass_dataA),
      .bypass_hitB(bypass_hitB), .bypass_dataB(bypass_dataB)
   );

   typedef struct packed {
      logic        v;
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   ent_t exp_q[$];
   ent_t out_m = '0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t lookup(input logic [4:0] a);
      if (a == 5'd0) return '0;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].v && mq[i].r == a) return '{1'b1, a, mq[i].d};
      if (out_m.v && out_m.r == a) return out_m;
      return '0;
   endfunction

   task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mr, input logic [31:0] mdd,
                       input logic [4:0] ra, input logic [4:0] rb);
      ent_t ba, bb;
      bit acc;
      @(negedge clock);
      alu_wbValid = av; alu_wbReg = ar; alu_wbData = ad;
      md_valid = mv; md_reg = mr; md_data = mdd;
      ctrl_readRegA = ra; ctrl_readRegB = rb;
      #1;
      acc = mq.size() < QD;
      chk("md_ready", {31'd0, md_ready}, {31'd0, acc});
      ba = lookup(ra);
      bb = lookup(rb);
      chk("hitA", {31'd0, bypass_hitA}, {31'd0, ba.v});
      chk("dataA", bypass_dataA, ba.d);
      chk("hitB", {31'd0, bypass_hitB}, {31'd0, bb.v});
      chk("dataB", bypass_dataB, bb.d);
      if (av && ar != 0) begin
         foreach (mq[i]) if (mq[i].r == ar) mq[i].v = 1'b0;
         out_m = '{1'b1, ar, ad};
      end else if (mq.size() > 0) begin
         out_m = mq.pop_front();
      end else begin
         out_m.v = 1'b0;
      end
      if (mv && acc && mr != 0 && !(av && ar == mr)) mq.push_back('{1'b1, mr, mdd});
      exp_q.push_back(out_m);
   endtask

   task automatic idle(input int n, input logic [4:0] ra);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, ra, 0);
   endtask

   task automatic do_reset(input logic [4:0] ra);
      @(negedge clock);
      alu_wbValid = 0; md_valid = 0; ctrl_readRegA = ra; ctrl_readRegB = ra;
      #2 ctrl_reset = 1'b1;
      #1;
      chk("rst_we", {31'd0, ctrl_writeEnable}, 0);
      chk("rst_reg", {27'd0, ctrl_writeReg}, 0);
      chk("rst_data", data_writeReg, 0);
      chk("rst_ready", {31'd0, md_ready}, 0);
      chk("rst_hitA", {31'd0, bypass_hitA}, 0);
      chk("rst_dataB", bypass_dataB, 0);
      mq.delete();
      exp_q.delete();
      out_m = '0;
      @(negedge clock);
      ctrl_reset = 1'b0;
   endtask

   initial begin : monitor
      ent_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we", {31'd0, ctrl_writeEnable}, {31'd0, e.v});
            chk("wreg", {27'd0, ctrl_writeReg}, {27'd0, e.r});
            chk("wdata", data_writeReg, e.d);
         end
      end
   end

   initial begin : driver
      int sent, cyc;
      #1 ctrl_reset = 1'b1;
      #1;
      chk("init_we", {31'd0, ctrl_writeEnable}, 0);
      chk("init_ready", {31'd0, md_ready}, 0);
      repeat (2) @(posedge clock);
      @(negedge clock) ctrl_reset = 1'b0;
      idle(2, 0);

      // ALU write and its bypass
      step(1, 5, 32'h1234, 0, 0, 0, 0, 0);
      @(posedge clock); #2;
      chk("alu_we_r5", {31'd0, ctrl_writeEnable}, 1);
      chk("alu_data_r5", data_writeReg, 32'h1234);
      idle(1, 5);

      // Contention: queue fills under ALU traffic, then drains in order
      step(1, 1, 32'h1, 1, 7, 32'hAA, 7, 0);
      step(1, 2, 32'h2, 1, 8, 32'hBB, 8, 7);
      step(1, 3, 32'h3, 1, 9, 32'hCC, 0, 0);
      idle(4, 8);

      // Kill of a queued entry by a younger ALU write
      step(1, 10, 32'h10, 1, 9, 32'h11, 9, 0);
      step(1, 9, 32'h22, 0, 0, 0, 9, 0);
      idle(3, 9);

      // Same-cycle discard and r0 handling
      step(1, 4, 32'h44, 1, 4, 32'h55, 4, 0);
      idle(2, 4);
      step(1, 0, 32'h99, 1, 0, 32'h77, 0, 0);
      idle(2, 0);

      // Wrap-around: six results through alternating busy/idle cycles
      sent = 0;
      cyc = 0;
      while (sent < 6 && cyc < 100) begin
         bit acc;
         acc = mq.size() < QD;
         step(cyc % 2 == 1, 20, 32'(cyc), 1, 5'(11 + sent), 32'h500 + 32'(sent), 5'(11 + sent), 20);
         if (acc) sent++;
         cyc++;
      end
      chk("wrap_sent", 32'(sent), 6);
      idle(6, 16);

      // Reset with a full queue discards it
      step(1, 1, 32'h1, 1, 12, 32'hE1, 0, 0);
      step(1, 2, 32'h2, 1, 13, 32'hE2, 0, 0);
      do_reset(12);
      idle(4, 12);

      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset(5'($urandom_range(1, 7)));
         step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(4, 0);
      @(posedge clock); #2;
      chk("drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
